// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared constants, state encoding and width helper for the LFSR sampler
package lfsr_pkg;

    localparam int unsigned LFSR_W      = 8;
    localparam int unsigned DEF_DIV     = 16;
    localparam int unsigned DEF_TIMEOUT = 8;
    localparam int unsigned DEF_PWM_W   = 4;

    typedef enum logic {
        COUNT = 1'b0,
        ARM   = 1'b1
    } state_e;

    // Bits needed to count 0..range-1, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned range);
        return (range > 1) ? $clog2(range) : 1;
    endfunction

endpackage

// File: rtl/led_pwm.sv
// rtl/led_pwm.sv - free-running PWM counter and registered LED gating of the held sample
module led_pwm
    import lfsr_pkg::*;
#(
    parameter int unsigned PWM_W = DEF_PWM_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PWM_W-1:0]  duty,
    input  logic [LFSR_W-1:0] sample_out,
    output logic [LFSR_W-1:0] Led
);

    logic [PWM_W-1:0]  pwm_cnt_q;
    logic [PWM_W-1:0]  pwm_cnt_d;
    logic              pwm_on;
    logic [LFSR_W-1:0] led_q;
    logic [LFSR_W-1:0] led_d;

    // Counter wraps naturally at 2^PWM_W-1 -> 0; duty=0 never lights, max duty leaves one dark slot.
    always_comb begin
        pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
        pwm_on    = (pwm_cnt_q < duty);
        led_d     = pwm_on ? sample_out : '0;
    end

    // PWM counter and Led register; Led lags the counter by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt_q <= '0;
            led_q     <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            led_q     <= led_d;
        end
    end

    assign Led = led_q;

endmodule

// File: rtl/lfsr_led_sampler.sv
// rtl/lfsr_led_sampler.sv - periodic LFSR byte sampler with stall timeout and PWM LED drive; LFSR_ZERO_DET_EN rejects all-zero samples
module lfsr_led_sampler
    import lfsr_pkg::*;
#(
    parameter int unsigned DIV     = DEF_DIV,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT,
    parameter int unsigned PWM_W   = DEF_PWM_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LFSR_W-1:0] rnd_in,
    input  logic              rnd_valid,
    input  logic              freeze,
    input  logic [PWM_W-1:0]  duty,
    output logic [LFSR_W-1:0] Led,
    output logic [LFSR_W-1:0] sample_out,
    output logic              sample_stb,
    output logic              stall,
    output logic              zero_err
);

    localparam int unsigned CNT_W = cnt_width(DIV);
    localparam int unsigned TMO_W = cnt_width(TIMEOUT);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    state_e            state_q;
    state_e            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [TMO_W-1:0]  tmo_q;
    logic [TMO_W-1:0]  tmo_d;
    logic [LFSR_W-1:0] sample_q;
    logic              stb_q;
    logic              stall_q;

    logic              wrap;
    logic              tmo_last;
    logic              take;
    logic              timed_out;
    logic              accept;

    assign wrap     = (cnt_q == CNT_LAST);
    assign tmo_last = (tmo_q == TMO_LAST);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= COUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a prescaler wrap requests a sample unless frozen; ARM ends on data or timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            COUNT: begin
                if (wrap && !freeze) begin
                    state_d = ARM;
                end
            end
            ARM: begin
                if (rnd_valid || tmo_last) begin
                    state_d = COUNT;
                end
            end
            default: state_d = COUNT;
        endcase
    end

    // Per-state controls: counter updates, capture and timeout decisions (sample beats timeout).
    always_comb begin
        cnt_d     = cnt_q;
        tmo_d     = '0;
        take      = 1'b0;
        timed_out = 1'b0;
        case (state_q)
            COUNT: begin
                cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
            end
            ARM: begin
                cnt_d     = '0;
                take      = rnd_valid;
                timed_out = !rnd_valid && tmo_last;
                tmo_d     = (take || timed_out) ? '0 : tmo_q + TMO_W'(1);
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    // Prescaler and timeout counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            tmo_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end

`ifdef LFSR_ZERO_DET_EN
    logic zerr_q;

    // An all-zero byte means the LFSR locked up, so it is never published as a sample.
    assign accept = (rnd_in != '0);

    // Sticky lockup flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zerr_q <= 1'b0;
        end else if (take && !accept) begin
            zerr_q <= 1'b1;
        end
    end

    assign zero_err = zerr_q;
`else
    assign accept   = 1'b1;
    assign zero_err = 1'b0;
`endif

    // Held sample, one-cycle strobe after each capture attempt, and sticky stall flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_q <= '0;
            stb_q    <= 1'b0;
            stall_q  <= 1'b0;
        end else begin
            stb_q <= take;
            if (take && accept) begin
                sample_q <= rnd_in;
            end
            if (timed_out) begin
                stall_q <= 1'b1;
            end
        end
    end

    assign sample_out = sample_q;
    assign sample_stb = stb_q;
    assign stall      = stall_q;

    led_pwm #(
        .PWM_W (PWM_W)
    ) u_led_pwm (
        .clk        (clk),
        .rst        (rst),
        .duty       (duty),
        .sample_out (sample_q),
        .Led        (Led)
    );

endmodule

// File: tb/tb_lfsr_led_sampler.sv
// tb/tb_lfsr_led_sampler.sv - self-checking bench for lfsr_led_sampler with a behavioural reference model
module tb_lfsr_led_sampler;

    localparam int DIV     = 4;
    localparam int TIMEOUT = 3;
    localparam int PWM_W   = 4;

`ifdef LFSR_ZERO_DET_EN
    localparam bit ZDET = 1'b1;
`else
    localparam bit ZDET = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       rnd_in;
    logic             rnd_valid;
    logic             freeze;
    logic [PWM_W-1:0] duty;
    logic [7:0]       Led;
    logic [7:0]       sample_out;
    logic             sample_stb;
    logic             stall;
    logic             zero_err;

    int n_cmp = 0;
    int n_bad = 0;

    lfsr_led_sampler #(
        .DIV     (DIV),
        .TIMEOUT (TIMEOUT),
        .PWM_W   (PWM_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rnd_in     (rnd_in),
        .rnd_valid  (rnd_valid),
        .freeze     (freeze),
        .duty       (duty),
        .Led        (Led),
        .sample_out (sample_out),
        .sample_stb (sample_stb),
        .stall      (stall),
        .zero_err   (zero_err)
    );

    always #5 clk = ~clk;

    // Reference model: m_t is the position in the sample period (0..DIV-1 counting, DIV.. waiting),
    // m_cyc counts cycles since reset so the PWM slot is m_cyc mod 2^PWM_W.
    int         m_t;
    int         m_cyc;
    logic [7:0] e_sample;
    logic [7:0] e_led;
    logic       e_stb;
    logic       e_stall;
    logic       e_zerr;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_t      <= 0;
            m_cyc    <= 0;
            e_sample <= 8'h00;
            e_led    <= 8'h00;
            e_stb    <= 1'b0;
            e_stall  <= 1'b0;
            e_zerr   <= 1'b0;
        end else begin
            m_cyc <= m_cyc + 1;
            e_led <= ((m_cyc % (1 << PWM_W)) < int'(duty)) ? e_sample : 8'h00;
            e_stb <= 1'b0;
            if (m_t < DIV - 1) begin
                m_t <= m_t + 1;
            end else if (m_t == DIV - 1) begin
                m_t <= freeze ? 0 : DIV;
            end else if (rnd_valid) begin
                m_t   <= 0;
                e_stb <= 1'b1;
                if (ZDET && rnd_in == 8'h00) e_zerr <= 1'b1;
                else e_sample <= rnd_in;
            end else if (m_t - DIV == TIMEOUT - 1) begin
                m_t     <= 0;
                e_stall <= 1'b1;
            end else begin
                m_t <= m_t + 1;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        rnd_valid = 1'b0;
        rnd_in    = 8'h00;
        freeze    = 1'b0;
        duty      = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Advances negedge by negedge until sample_stb is seen; k is the number of cycles taken (30 = never).
    task automatic wait_stb(output int k);
        k = 0;
        while (k < 30) begin
            @(negedge clk);
            k++;
            if (sample_stb === 1'b1) break;
        end
    endtask

    task automatic test_reset();
        int k;
        rst = 1'b1; rnd_valid = 1'b0; rnd_in = 8'h00; freeze = 1'b0; duty = 4'd15;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (sample_out !== 8'h00) begin n_bad++; $display("FAIL reset_sample: got %0h want 0", sample_out); end
        n_cmp++; if (Led !== 8'h00) begin n_bad++; $display("FAIL reset_led: got %0h want 0", Led); end
        n_cmp++; if ({sample_stb, stall, zero_err} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b want 000", {sample_stb, stall, zero_err}); end
        rst = 1'b0;
        rnd_valid = 1'b1; rnd_in = 8'h81;
        wait_stb(k);
        rnd_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++; if ({sample_out, Led, sample_stb, stall, zero_err} !== 19'd0) begin n_bad++; $display("FAIL async_reset_outputs: sample=%0h led=%0h stb=%b stall=%b zerr=%b want all 0", sample_out, Led, sample_stb, stall, zero_err); end
        @(negedge clk);
        rst = 1'b0; rnd_valid = 1'b1; rnd_in = 8'h5A;
        wait_stb(k);
        n_cmp++; if (k !== 5) begin n_bad++; $display("FAIL reset_first_stb: got %0d cycles want 5", k); end
        n_cmp++; if (sample_out !== 8'h5A) begin n_bad++; $display("FAIL reset_first_sample: got %0h want 5a", sample_out); end
    endtask

    task automatic test_sample();
        int k;
        rnd_valid = 1'b1; rnd_in = 8'hA5;
        wait_stb(k);
        n_cmp++; if (k !== 5) begin n_bad++; $display("FAIL stb_period: got %0d want 5", k); end
        n_cmp++; if (sample_out !== 8'hA5) begin n_bad++; $display("FAIL sample_a5: got %0h want a5", sample_out); end
        @(negedge clk);
        n_cmp++; if (sample_stb !== 1'b0) begin n_bad++; $display("FAIL stb_one_cycle: got %b want 0", sample_stb); end
        rnd_in = 8'h17;
        wait_stb(k);
        n_cmp++; if (k !== 4) begin n_bad++; $display("FAIL stb_period_2: got %0d want 4 more", k); end
        n_cmp++; if (sample_out !== 8'h17) begin n_bad++; $display("FAIL sample_17: got %0h want 17", sample_out); end
    endtask

    task automatic test_stall();
        int k;
        do_reset();
        rnd_valid = 1'b1; rnd_in = 8'h5A;
        wait_stb(k);
        rnd_valid = 1'b0;
        repeat (6) @(negedge clk);
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL stall_early: got %b want 0", stall); end
        @(negedge clk);
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL stall_set: got %b want 1", stall); end
        n_cmp++; if (sample_out !== 8'h5A) begin n_bad++; $display("FAIL stall_sample_kept: got %0h want 5a", sample_out); end
        repeat (9) @(negedge clk);
        n_cmp++; if (stall !== 1'b1 || sample_stb !== 1'b0) begin n_bad++; $display("FAIL stall_sticky: stall=%b stb=%b want 1/0", stall, sample_stb); end
        do_reset();
        rnd_valid = 1'b1; rnd_in = 8'h5A;
        wait_stb(k);
        rnd_valid = 1'b0;
        repeat (6) @(negedge clk);
        rnd_valid = 1'b1; rnd_in = 8'hC3;
        @(negedge clk);
        n_cmp++; if (sample_stb !== 1'b1 || sample_out !== 8'hC3) begin n_bad++; $display("FAIL late_valid_sample: stb=%b sample=%0h want 1/c3", sample_stb, sample_out); end
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL late_valid_stall: got %b want 0", stall); end
    endtask

    task automatic test_freeze();
        int k;
        int stbs;
        do_reset();
        rnd_valid = 1'b1; rnd_in = 8'h11;
        wait_stb(k);
        freeze = 1'b1; rnd_in = 8'h22;
        stbs = 0;
        repeat (12) begin
            @(negedge clk);
            if (sample_stb === 1'b1) stbs++;
        end
        n_cmp++; if (stbs !== 0 || sample_out !== 8'h11) begin n_bad++; $display("FAIL freeze_hold: stbs=%0d sample=%0h want 0/11", stbs, sample_out); end
        freeze = 1'b0;
        wait_stb(k);
        n_cmp++; if (k !== 5 || sample_out !== 8'h22) begin n_bad++; $display("FAIL unfreeze_sample: k=%0d sample=%0h want 5/22", k, sample_out); end
    endtask

    task automatic test_pwm();
        int k;
        int on;
        int odd;
        do_reset();
        rnd_valid = 1'b1; rnd_in = 8'hFF;
        wait_stb(k);
        freeze = 1'b1;
        @(negedge clk);
        duty = 4'd4;
        on = 0; odd = 0;
        repeat (16) begin
            @(negedge clk);
            if (Led === 8'hFF) on++;
            else if (Led !== 8'h00) odd++;
        end
        n_cmp++; if (on !== 4 || odd !== 0) begin n_bad++; $display("FAIL pwm_duty4: on=%0d odd=%0d want 4/0", on, odd); end
        duty = 4'd0;
        on = 0;
        repeat (16) begin
            @(negedge clk);
            if (Led !== 8'h00) on++;
        end
        n_cmp++; if (on !== 0) begin n_bad++; $display("FAIL pwm_duty0: lit=%0d want 0", on); end
        duty = 4'd15;
        on = 0;
        repeat (16) begin
            @(negedge clk);
            if (Led === 8'h00) on++;
        end
        n_cmp++; if (on !== 1) begin n_bad++; $display("FAIL pwm_duty15: dark=%0d want 1", on); end
        freeze = 1'b0;
    endtask

    task automatic test_zero();
        int k;
        do_reset();
        rnd_valid = 1'b1; rnd_in = 8'h3C;
        wait_stb(k);
        rnd_in = 8'h00;
        wait_stb(k);
        n_cmp++; if (k !== 5) begin n_bad++; $display("FAIL zero_stb: got %0d want 5", k); end
`ifdef LFSR_ZERO_DET_EN
        n_cmp++; if (sample_out !== 8'h3C) begin n_bad++; $display("FAIL zero_reject: got %0h want 3c", sample_out); end
        @(negedge clk);
        n_cmp++; if (zero_err !== 1'b1) begin n_bad++; $display("FAIL zero_err_set: got %b want 1", zero_err); end
`else
        n_cmp++; if (sample_out !== 8'h00) begin n_bad++; $display("FAIL zero_accept: got %0h want 0", sample_out); end
        @(negedge clk);
        n_cmp++; if (zero_err !== 1'b0) begin n_bad++; $display("FAIL zero_err_off: got %b want 0", zero_err); end
`endif
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            n_cmp++; if (sample_out !== e_sample) begin n_bad++; $display("FAIL rand_sample @%0d: got %0h want %0h", i, sample_out, e_sample); end
            n_cmp++; if (sample_stb !== e_stb) begin n_bad++; $display("FAIL rand_stb @%0d: got %b want %b", i, sample_stb, e_stb); end
            n_cmp++; if (stall !== e_stall) begin n_bad++; $display("FAIL rand_stall @%0d: got %b want %b", i, stall, e_stall); end
            n_cmp++; if (zero_err !== e_zerr) begin n_bad++; $display("FAIL rand_zerr @%0d: got %b want %b", i, zero_err, e_zerr); end
            n_cmp++; if (Led !== e_led) begin n_bad++; $display("FAIL rand_led @%0d: got %0h want %0h", i, Led, e_led); end
            rnd_valid = ($urandom_range(0, 2) != 0);
            rnd_in    = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            freeze    = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 15) == 0) duty = PWM_W'($urandom);
            if ($urandom_range(0, 399) == 0) begin
                #2 rst = 1'b1;
                #1 rst = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_sample();
        test_stall();
        test_freeze();
        test_pwm();
        test_zero();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
